// File: rtl/cd_mesh_pkg.sv
// cd_mesh_pkg: shared sizes and helpers for the local converge crossbar
package cd_mesh_pkg;
  localparam int CD_DST_W   = 2;
  localparam int CD_NUM_RTR = 4;
  localparam int CD_NUM_CV  = 2;
  localparam int CD_DATA_W  = 64;
  localparam int CD_DST_LSB = 48;
  typedef logic [CD_DST_W-1:0] cd_dst_t;
  function automatic cd_dst_t cd_dest(input logic [CD_DATA_W-1:0] flit, input int lsb);
    return flit[lsb +: CD_DST_W];
  endfunction
endpackage

// File: rtl/cd_reply_rr2.sv
// cd_reply_rr2: two-requester round-robin arbiter with a one-bit priority register
module cd_reply_rr2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic prio;
  // priority flips to the other requester only when a grant actually transfers
  always_ff @(posedge clk or negedge reset)
    if (!reset) prio <= 1'b0;
    else if (en && |gnt) prio <= gnt[0];
  always_comb gnt = &req ? (prio ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/cd_reply_sched_2x4.sv
// cd_reply_sched_2x4: reply-path scheduler moving flits from 2 converged slots to 4 router outputs
module cd_reply_sched_2x4
  import cd_mesh_pkg::*;
#(
  parameter int DATA_W  = CD_DATA_W,
  parameter int DST_LSB = CD_DST_LSB,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CD_NUM_CV-1:0]         cv_si_r,
  output logic [CD_NUM_CV-1:0]         cv_ri_r,
  input  logic [CD_NUM_CV*DATA_W-1:0]  cv_di_r,
  output logic [CD_NUM_RTR-1:0]        out_so,
  input  logic [CD_NUM_RTR-1:0]        out_ro,
  output logic [CD_NUM_RTR*DATA_W-1:0] out_do,
  output logic [CNT_W-1:0]             stat_conflicts
);
  logic [CD_NUM_CV-1:0] slot_v, deq;
  logic [DATA_W-1:0] slot_d [CD_NUM_CV];
  cd_dst_t dst [CD_NUM_CV];
  logic [1:0] req [CD_NUM_RTR];
  logic [1:0] gnt [CD_NUM_RTR];
  logic conflict;
  always_comb
    for (int i = 0; i < CD_NUM_CV; i++) dst[i] = cd_dest(CD_DATA_W'(slot_d[i]), DST_LSB);
  always_comb
    for (int k = 0; k < CD_NUM_RTR; k++)
      req[k] = {slot_v[1] && dst[1] == cd_dst_t'(k), slot_v[0] && dst[0] == cd_dst_t'(k)};
  genvar k;
  generate
    for (k = 0; k < CD_NUM_RTR; k++) begin : g_arb
      cd_reply_rr2 u_rr (.clk(clk), .reset(reset), .req(req[k]), .en(out_ro[k]), .gnt(gnt[k]));
    end
  endgenerate
  // valid is gated by downstream ready, so out_so marks an actual transfer
  always_comb begin
    out_so = '0;
    out_do = '0;
    deq = '0;
    conflict = 1'b0;
    for (int j = 0; j < CD_NUM_RTR; j++) begin
      out_so[j] = |gnt[j] && out_ro[j];
      out_do[j*DATA_W +: DATA_W] = gnt[j][0] ? slot_d[0] : gnt[j][1] ? slot_d[1] : '0;
      deq = deq | (out_so[j] ? gnt[j] : 2'b00);
      conflict = conflict | (&req[j] && out_ro[j]);
    end
    cv_ri_r = ~slot_v | deq;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      slot_v <= '0;
      stat_conflicts <= '0;
    end else begin
      for (int i = 0; i < CD_NUM_CV; i++)
        if (cv_si_r[i] && cv_ri_r[i]) slot_v[i] <= 1'b1;
        else if (deq[i]) slot_v[i] <= 1'b0;
      if (conflict && !(&stat_conflicts)) stat_conflicts <= stat_conflicts + 1'b1;
    end
  always_ff @(posedge clk)
    for (int i = 0; i < CD_NUM_CV; i++)
      if (cv_si_r[i] && cv_ri_r[i]) slot_d[i] <= cv_di_r[i*DATA_W +: DATA_W];
endmodule

// File: tb/tb_cd_reply_sched_2x4.sv
// tb_cd_reply_sched_2x4: directed and random checks of the reply scheduler against a behavioural model
module tb_cd_reply_sched_2x4;
  logic clk = 1'b0, reset = 1'b0, run = 1'b0;
  logic [1:0] cv_si_r = '0, cv_ri_r, ri4;
  logic [127:0] cv_di_r = '0;
  logic [3:0] out_so, so4, out_ro = '0;
  logic [255:0] out_do, do4;
  logic [15:0] stat, base;
  logic [3:0] stat4;
  logic [63:0] f0, f1, p0, p1;
  int tests = 0, fails = 0;
  logic mv [2];
  logic [63:0] md [2];
  int mprio [4];
  int mcnt, mcnt4, n, w;
  logic [3:0] e_so;
  logic [255:0] e_do;
  logic [1:0] e_ri;
  logic e_conf;
  int e_win [4];

  cd_reply_sched_2x4 dut (.clk(clk), .reset(reset), .cv_si_r(cv_si_r), .cv_ri_r(cv_ri_r),
    .cv_di_r(cv_di_r), .out_so(out_so), .out_ro(out_ro), .out_do(out_do), .stat_conflicts(stat));
  cd_reply_sched_2x4 #(.CNT_W(4)) dut4 (.clk(clk), .reset(reset), .cv_si_r(cv_si_r), .cv_ri_r(ri4),
    .cv_di_r(cv_di_r), .out_so(so4), .out_ro(out_ro), .out_do(do4), .stat_conflicts(stat4));

  always #5 clk = ~clk;

  function automatic int dst(logic [63:0] f);
    return int'(f[49:48]);
  endfunction

  function automatic logic [63:0] mk(int dest, int tag);
    logic [63:0] f = {$urandom, $urandom};
    f[49:48] = 2'(dest);
    f[0] = tag[0];
    return f;
  endfunction

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mid;
    @(negedge clk);
    #1;
  endtask

  task automatic nx;
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_in;
    cv_si_r = 2'($urandom);
    cv_di_r = {mk(int'($urandom_range(3)), 1), mk(int'($urandom_range(3)), 0)};
    out_ro = 4'($urandom);
  endtask

  // what the outputs must be given the held flits, priorities and current inputs
  always_comb begin
    e_so = '0;
    e_do = '0;
    e_ri = '0;
    e_conf = 1'b0;
    n = 0;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      w = -1;
      for (int i = 0; i < 2; i++)
        if (mv[i] === 1'b1 && dst(md[i]) == k) begin
          n++;
          w = i;
        end
      if (n == 2) w = mprio[k];
      e_win[k] = w;
      if (w >= 0) begin
        e_so[k] = out_ro[k];
        e_do[k*64 +: 64] = md[w];
      end
      if (n == 2 && out_ro[k]) e_conf = 1'b1;
    end
    for (int i = 0; i < 2; i++)
      e_ri[i] = !mv[i] || (e_so[dst(md[i])] && e_win[dst(md[i])] == i);
  end

  always @(posedge clk or negedge reset)
    if (!reset) begin
      mv <= '{1'b0, 1'b0};
      mprio <= '{0, 0, 0, 0};
      mcnt <= 0;
      mcnt4 <= 0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (e_win[k] >= 0 && out_ro[k]) mprio[k] <= 1 - e_win[k];
      for (int i = 0; i < 2; i++)
        if (cv_si_r[i] && e_ri[i]) begin
          mv[i] <= 1'b1;
          md[i] <= cv_di_r[i*64 +: 64];
        end else if (e_ri[i]) mv[i] <= 1'b0;
      if (e_conf) begin
        mcnt <= (mcnt < 65535) ? mcnt + 1 : mcnt;
        mcnt4 <= (mcnt4 < 15) ? mcnt4 + 1 : mcnt4;
      end
    end

  always @(negedge clk)
    if (run) begin
      chk("so", out_so, e_so);
      chk("do", out_do, e_do);
      chk("ri", cv_ri_r, e_ri);
      chk("cnt", stat, mcnt[15:0]);
      chk("cnt4", stat4, mcnt4[3:0]);
      chk("so4", so4, e_so);
      chk("ri4", ri4, e_ri);
      chk("do4", do4, e_do);
    end

  initial begin
    nx();
    run = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rnd_in();
      mid();
      chk("rst_so", out_so, 0);
      chk("rst_do", out_do, 0);
      chk("rst_cnt", stat, 0);
      chk("rst_ri", cv_ri_r, 2'b11);
      nx();
    end
    reset = 1'b1;
    out_ro = 4'hF;
    f0 = mk(2, 0);
    cv_si_r = 2'b01;
    cv_di_r = {64'd0, f0};
    nx();
    cv_si_r = 2'b00;
    mid();
    chk("first_so", out_so, 4'b0100);
    chk("first_do", out_do[191:128], f0);
    nx();
    for (int c = 0; c < 8; c++) begin
      f0 = mk(1, 0);
      f1 = mk(3, 1);
      cv_si_r = 2'b11;
      cv_di_r = {f1, f0};
      mid();
      chk("str_ri", cv_ri_r, 2'b11);
      if (c > 0) begin
        chk("str_so", out_so, 4'b1010);
        chk("str_d1", out_do[127:64], p0);
        chk("str_d3", out_do[255:192], p1);
      end
      p0 = f0;
      p1 = f1;
      nx();
    end
    cv_si_r = 2'b00;
    nx();
    base = stat;
    for (int c = 0; c < 24; c++) begin
      cv_si_r = 2'b11;
      cv_di_r = {mk(0, 1), mk(0, 0)};
      mid();
      if (c > 0) begin
        chk("cf_so", out_so, 4'b0001);
        chk("cf_win", out_do[0], (c - 1) % 2);
        chk("cf_ri", cv_ri_r, (c % 2 == 1) ? 2'b01 : 2'b10);
        chk("cf_cnt", stat - base, c - 1);
      end
      nx();
    end
    chk("sat4", stat4, 4'hF);
    cv_si_r = 2'b00;
    repeat (3) nx();
    out_ro = 4'b1011;
    f0 = mk(2, 0);
    f1 = mk(2, 1);
    cv_si_r = 2'b11;
    cv_di_r = {f1, f0};
    nx();
    cv_si_r = 2'b00;
    base = stat;
    for (int c = 0; c < 5; c++) begin
      mid();
      chk("st_so", out_so[2], 0);
      chk("st_ri", cv_ri_r, 2'b00);
      chk("st_d", out_do[191:128], f1);
      chk("st_cnt", stat, base);
      nx();
    end
    out_ro = 4'hF;
    mid();
    chk("st_rel_so", out_so, 4'b0100);
    chk("st_rel_d", out_do[191:128], f1);
    nx();
    mid();
    chk("st_rel2_d", out_do[191:128], f0);
    nx();
    for (int c = 0; c < 3000; c++) begin
      rnd_in();
      nx();
    end
    out_ro = 4'h0;
    cv_si_r = 2'b11;
    cv_di_r = {mk(1, 1), mk(2, 0)};
    nx();
    cv_si_r = 2'b00;
    nx();
    mid();
    chk("mr_full", cv_ri_r, 2'b00);
    #1 reset = 1'b0;
    #1;
    chk("mr_ri", cv_ri_r, 2'b11);
    chk("mr_cnt", stat, 0);
    out_ro = 4'hF;
    #1;
    chk("mr_so", out_so, 0);
    chk("mr_do", out_do, 0);
    nx();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mid();
      chk("mr_stale", out_so, 0);
      nx();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
